// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encoding, oversampling and baud divider.
// Used by the receiver, the transmitter and the baud-rate generator.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = OVERSAMPLE / 2 - 1;
  localparam int BAUD_DIV   = 100_000_000 / 9600 / 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver, LSB first, idle-high line.
// Samples every bit at mid-period and leaves the frame at mid-stop-bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (br_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            // A start bit that is gone by mid-bit was only a glitch
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (br_tick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (br_tick) begin
          if (tick_q == TICK_LAST) begin
            data_d  = shift_q;
            err_d   = ~rx_s;
            done_d  = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table, corner
// sequences, random frames vs a frame-level model, baud drift.
module tb_uart_receiver;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       br_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int fails = 0;
  int tick_div = 4;
  int tick_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  logic [7:0] got_data[$];
  logic       got_err[$];
  logic [7:0] exp_data[$];
  logic       exp_err[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  uart_receiver #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .br_tick   (br_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      br_tick = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      br_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done) begin
      checks = checks + 1;
      if (prev_done) begin
        fails = fails + 1;
        $display("FAIL done_width: rx_done high 2 clk, required 1 clk");
      end
      done_cnt = done_cnt + 1;
      got_data.push_back(rx_data);
      got_err.push_back(frame_err);
    end
    prev_done = rx_done;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low only long enough to be sampled,
  // so the follow-on START sees a high line and drops out cleanly.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int bc);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bc) @(negedge clk);
    end
    if (stop) begin
      rx = 1'b1;
      repeat (bc) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (bc * 5 / 8) @(negedge clk);
      rx = 1'b1;
      repeat (bc - bc * 5 / 8) @(negedge clk);
    end
  endtask

  initial begin
    int n0;
    int bc;
    int nom;
    int gap;
    logic [7:0] d;
    logic st;
    logic prev_bad;
    logic [7:0] bb[3];

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[2] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_done", 32'(rx_done), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    reset = 1'b1;
    idle(20);

    for (int i = 0; i < 5; i++) begin
      n0 = done_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 64);
      idle(100);
      check("vec_done_count", 32'(done_cnt - n0), 32'd1);
      check("vec_data", 32'(rx_data), 32'(vecs[i].exp_data));
      check("vec_err", 32'(frame_err), 32'(vecs[i].exp_err));
      check("vec_busy", 32'(rx_busy), 32'h0);
    end

    n0 = done_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(rx_busy), 32'h1);
    idle(100);
    check("glitch_no_done", 32'(done_cnt - n0), 32'd0);
    check("glitch_data", 32'(rx_data), 32'hFF);
    check("glitch_err", 32'(frame_err), 32'h1);
    check("glitch_idle", 32'(rx_busy), 32'h0);

    got_data.delete();
    got_err.delete();
    bb[0] = 8'h00;
    bb[1] = 8'hFF;
    bb[2] = 8'h81;
    n0 = done_cnt;
    for (int i = 0; i < 3; i++) send_frame(bb[i], 1'b1, 64);
    idle(100);
    check("b2b_count", 32'(done_cnt - n0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_data.size()) begin
        check("b2b_data", 32'(got_data[i]), 32'(bb[i]));
        check("b2b_err", 32'(got_err[i]), 32'h0);
      end
    end

    n0 = done_cnt;
    d = 8'h96;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    rx = d[3];
    repeat (32) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_done", 32'(rx_done), 32'h0);
    check("midreset_err", 32'(frame_err), 32'h0);
    check("midreset_busy", 32'(rx_busy), 32'h0);
    repeat (5) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    idle(100);
    check("midreset_no_done", 32'(done_cnt - n0), 32'd0);
    n0 = done_cnt;
    send_frame(8'h12, 1'b1, 64);
    idle(100);
    check("post_reset_count", 32'(done_cnt - n0), 32'd1);
    check("post_reset_data", 32'(rx_data), 32'h12);
    check("post_reset_err", 32'(frame_err), 32'h0);

    got_data.delete();
    got_err.delete();
    prev_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      if (prev_bad) gap = $urandom_range(100, 140);
      else if ($urandom_range(0, 1) == 0) gap = 0;
      else gap = $urandom_range(1, 80);
      if (gap > 0) idle(gap);
      send_frame(d, st, 64);
      exp_data.push_back(d);
      exp_err.push_back(~st);
      prev_bad = ~st;
    end
    idle(120);
    check("rand_count", 32'(got_data.size()), 32'(exp_data.size()));
    while (got_data.size() > 0 && exp_data.size() > 0) begin
      check("rand_data", 32'(got_data.pop_front()),
            32'(exp_data.pop_front()));
      check("rand_err", 32'(got_err.pop_front()),
            32'(exp_err.pop_front()));
    end

    tick_div = BAUD_DIV / 16;
    nom = 16 * tick_div;
    idle(2 * nom);
    for (int k = 0; k < 2; k++) begin
      bc = (k == 0) ? nom * 103 / 100 : nom * 97 / 100;
      n0 = done_cnt;
      send_frame(8'h41, 1'b1, bc);
      idle(2 * nom);
      check("drift_count", 32'(done_cnt - n0), 32'd1);
      check("drift_data", 32'(rx_data), 32'h41);
      check("drift_err", 32'(frame_err), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 16x-oversampled UART receiver: 8N1, LSB first, idle-high line. It is the downstream counterpart of the UART transmitter.
- It shares the same free-running baud tick (100 MHz / 9600 / 16) with the transmitter.
- It recovers each serial frame from the rx pin into a parallel byte and pulses a one-clock done strobe.
- It flags framing errors on the stop bit and sits between the board rx pin and the byte consumer logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first).
- OVERSAMPLE, 16, br_tick pulses per bit period.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- br_tick  input  1  one-clk-wide oversample tick from the baud-rate generator.
- rx  input  1  asynchronous serial input, idle high.
- rx_data  output  DATA_BITS  last received byte, held until the next frame completes.
- rx_done  output  1  one-clk pulse when rx_data/frame_err are updated.
- frame_err  output  1  1 = stop bit sampled low on the last frame; held until the next rx_done.
- rx_busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift=0.
  - rx_data=0; rx_done=0; frame_err=0; rx_busy=0.
  - Both synchronizer flops=1.
  - Reset mid-frame aborts the frame; no rx_done is produced for the aborted frame.
- Input sync: rx passes through 2 flops (rx_s). All decisions use rx_s only, so there are 2 clk of latency from the pin.
- The FSM has four states: IDLE, START, DATA, STOP. Counters advance only on clocks where br_tick==1.
- IDLE:
  - rx_busy=0.
  - If rx_s==0 (checked every clk, not gated by br_tick): go to START, tick_cnt=0.
- START:
  - On br_tick, if tick_cnt==OVERSAMPLE/2-1 (7):
    - rx_s==0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s==1: glitch; return to IDLE with no rx_done and no frame_err change.
  - Otherwise tick_cnt++.
- DATA:
  - On br_tick, if tick_cnt==OVERSAMPLE-1 (15):
    - shift={rx_s, shift[DATA_BITS-1:1]}; tick_cnt=0.
    - If bit_cnt==DATA_BITS-1, go to STOP; else bit_cnt++.
  - Otherwise tick_cnt++.
  - Samples land at mid-bit.
- STOP:
  - On br_tick, if tick_cnt==15:
    - rx_data<=shift; frame_err<=~rx_s; rx_done<=1 for exactly one clk.
    - tick_cnt=0; go to IDLE.
  - Otherwise tick_cnt++.
  - The FSM leaves at mid-stop-bit, so a following start bit is never missed at full line rate (back-to-back frames).
- Latency: 8+128+16=152 br_ticks after entering START, then +1 clk to rx_done. This is ~9.5 bit times after the falling edge at the pin.
- On framing error the data is still delivered: rx_data updated, frame_err=1 with rx_done. The FSM returns to IDLE; if rx stays low, it re-enters START on the next clk.
- br_tick asserted for consecutive clocks: each clk counts as one tick; there is no edge detection.
- rx_done never asserts outside STOP→IDLE; never two pulses per frame.
- Counter widths: tick_cnt $clog2(OVERSAMPLE), bit_cnt $clog2(DATA_BITS). No wrap beyond the compare values.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/STOP (2-bit);
  - OVERSAMPLE=16;
  - MID_TICK=OVERSAMPLE/2-1;
  - BAUD_DIV=100_000_000/9600/16 (shared with the baud-rate generator and transmitter).
- One sub-module: uart_rx_sync, a 2-flop synchronizer with reset value 1 (active-low async reset).
- Counter/FSM logic stays in uart_receiver using the registered-state plus next-state combinational style.

Test Plan:
- Bench drives br_tick every 4 clk. Serialize 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> one rx_done pulse; rx_data=0xA5; frame_err=0; rx_busy back to 0.
- Low glitch on rx of 3 br_ticks, then high -> FSM returns to IDLE from START; no rx_done; rx_data unchanged.
- 0x3C sent with stop bit=0 -> rx_done with rx_data=0x3C, frame_err=1. Then 0x55 with a valid stop -> frame_err=0, rx_data=0x55.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> exactly three rx_done pulses, correct bytes in order.
- Assert reset during the 4th data bit of 0x96 -> all outputs 0 immediately. Release, then send 0x12 -> rx_data=0x12, single rx_done.
- Real baud generator (BAUD_DIV=651), byte 0x41 at 9600 bps with the rx edge offset ±3% of a bit period -> rx_data=0x41, frame_err=0.
